// File: rtl/pc_ras.sv
// Program counter with increment/branch/jump/hold and a circular return-address stack.
// Optional macro PC_RAS_TRAP_EN: RET on an empty stack goes to TRAP_VECTOR instead of PC+1.
module pc_ras #(
   parameter int                WIDTH        = 16,
   parameter int                RAS_DEPTH    = 4,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0]  TRAP_VECTOR  = 16'hFFF0,
   localparam int               CW           = $clog2(RAS_DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             ld_i,
   input  logic [2:0]       pcsel_i,
   input  logic [WIDTH-1:0] offset_i,
   input  logic [WIDTH-1:0] direct_i,
   input  logic             err_clr_i,
   output logic [WIDTH-1:0] pc_out_o,
   output logic [WIDTH-1:0] next_pc_o,
   output logic [CW-1:0]    ras_cnt_o,
   output logic             ras_empty_o,
   output logic             ras_full_o,
   output logic             ras_ovf_o,
   output logic             ras_unf_o
);

   localparam int PW = $clog2(RAS_DEPTH);

`ifdef PC_RAS_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      SEL_INC   = 3'b000,
      SEL_REL   = 3'b001,
      SEL_JMP   = 3'b010,
      SEL_HOLD  = 3'b011,
      SEL_CALL  = 3'b100,
      SEL_RET   = 3'b101,
      SEL_CALLR = 3'b110,
      SEL_RSVD  = 3'b111
   } pcsel_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] stack_q [RAS_DEPTH];

   logic [WIDTH-1:0] pc_inc, pc_rel, top_val, unf_target, next_pc;
   logic [PW-1:0]    ptr_inc, top_idx;
   logic             empty, full, push, pop, underflow;

   assign pc_inc     = pc_q + WIDTH'(1);
   assign pc_rel     = pc_q + offset_i;
   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == CW'(RAS_DEPTH));
   // ptr_q is the next write slot; the top of stack sits one below it.
   assign ptr_inc    = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
   assign top_idx    = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);
   assign top_val    = stack_q[top_idx];
   assign unf_target = TRAP_EN ? TRAP_VECTOR : pc_inc;

   always_comb begin
      next_pc   = pc_q;
      push      = 1'b0;
      pop       = 1'b0;
      underflow = 1'b0;
      case (pcsel_e'(pcsel_i))
         SEL_INC:   next_pc = pc_inc;
         SEL_REL:   next_pc = pc_rel;
         SEL_JMP:   next_pc = direct_i;
         SEL_CALL: begin
            push    = 1'b1;
            next_pc = direct_i;
         end
         SEL_RET: begin
            if (empty) begin
               underflow = 1'b1;
               next_pc   = unf_target;
            end else begin
               pop     = 1'b1;
               next_pc = top_val;
            end
         end
         SEL_CALLR: begin
            push    = 1'b1;
            next_pc = pc_rel;
         end
         default:   next_pc = pc_q;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      // Clear first so that an error arriving in the same cycle still sets the flag.
      ovf_d = err_clr_i ? 1'b0 : ovf_q;
      unf_d = err_clr_i ? 1'b0 : unf_q;
      if (ld_i) begin
         pc_d = next_pc;
         if (push) begin
            ptr_d = ptr_inc;
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CW'(1);
         end
         if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
         end
         if (underflow) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q  <= RESET_VECTOR;
         cnt_q <= '0;
         ptr_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // On overflow the write slot already holds the oldest entry, so it is simply overwritten.
   always_ff @(posedge clk_i) begin
      if (!reset_i && ld_i && push) begin
         stack_q[ptr_q] <= pc_inc;
      end
   end

   assign pc_out_o    = pc_q;
   assign next_pc_o   = next_pc;
   assign ras_cnt_o   = cnt_q;
   assign ras_empty_o = empty;
   assign ras_full_o  = full;
   assign ras_ovf_o   = ovf_q;
   assign ras_unf_o   = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed test-plan steps followed by random operations, checked against a queue-based model.
module tb_pc_ras;

   localparam int          W     = 16;
   localparam int          DEPTH = 4;
   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [W-1:0] RV   = 16'h0000;
   localparam logic [W-1:0] TV   = 16'hFFF0;

   logic          clk = 1'b0;
   logic          reset, ld, err_clr;
   logic [2:0]    pcsel;
   logic [W-1:0]  offset, direct;
   logic [W-1:0]  pc_out, next_pc;
   logic [CW-1:0] ras_cnt;
   logic          ras_empty, ras_full, ras_ovf, ras_unf;

   pc_ras #(.WIDTH(W), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk_i(clk), .reset_i(reset), .ld_i(ld), .pcsel_i(pcsel),
      .offset_i(offset), .direct_i(direct), .err_clr_i(err_clr),
      .pc_out_o(pc_out), .next_pc_o(next_pc), .ras_cnt_o(ras_cnt),
      .ras_empty_o(ras_empty), .ras_full_o(ras_full),
      .ras_ovf_o(ras_ovf), .ras_unf_o(ras_unf)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model state: PC, stack as a queue (back = top), sticky flags.
   logic [W-1:0] m_pc;
   logic [W-1:0] m_stk [$];
   bit           m_ovf, m_unf;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] model_next(input logic [2:0] sel, input logic [W-1:0] off,
                                               input logic [W-1:0] dir);
      case (sel)
         3'd0: return m_pc + 16'd1;
         3'd1: return m_pc + off;
         3'd2: return dir;
         3'd4: return dir;
         3'd5: begin
            if (m_stk.size() == 0) begin
`ifdef PC_RAS_TRAP_EN
               return TV;
`else
               return m_pc + 16'd1;
`endif
            end
            return m_stk[$];
         end
         3'd6: return m_pc + off;
         default: return m_pc;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit l, input logic [2:0] sel,
                             input logic [W-1:0] off, input logic [W-1:0] dir, input bit clr);
      logic [W-1:0] nxt;
      bit novf, nunf;
      if (rst) begin
         m_pc = RV;
         m_stk.delete();
         m_ovf = 0;
         m_unf = 0;
         return;
      end
      nxt  = model_next(sel, off, dir);
      novf = 0;
      nunf = 0;
      if (l) begin
         if (sel == 3'd4 || sel == 3'd6) begin
            if (m_stk.size() == DEPTH) begin
               novf = 1;
               void'(m_stk.pop_front());
            end
            m_stk.push_back(m_pc + 16'd1);
         end else if (sel == 3'd5) begin
            if (m_stk.size() == 0) nunf = 1;
            else void'(m_stk.pop_back());
         end
         m_pc = nxt;
      end
      m_ovf = novf | (clr ? 1'b0 : m_ovf);
      m_unf = nunf | (clr ? 1'b0 : m_unf);
   endtask

   // One clock: drive at negedge, check NEXT_PC, clock, then check registered state.
   task automatic cyc(input bit rst, input bit l, input logic [2:0] sel,
                      input logic [W-1:0] off, input logic [W-1:0] dir, input bit clr);
      reset = rst; ld = l; pcsel = sel; offset = off; direct = dir; err_clr = clr;
      #1;
      check("next_pc", next_pc, model_next(sel, off, dir));
      @(posedge clk);
      model_step(rst, l, sel, off, dir, clr);
      @(negedge clk);
      check("pc_out", pc_out, m_pc);
      check("ras_cnt", W'(ras_cnt), W'(m_stk.size()));
      check("ras_empty", W'(ras_empty), W'(m_stk.size() == 0));
      check("ras_full", W'(ras_full), W'(m_stk.size() == DEPTH));
      check("ras_ovf", W'(ras_ovf), W'(m_ovf));
      check("ras_unf", W'(ras_unf), W'(m_unf));
      $display("t=%0t rst=%0d ld=%0d sel=%0d off=%h dir=%h clr=%0d -> pc=%h cnt=%0d ovf=%0d unf=%0d",
               $time, rst, l, sel, off, dir, clr, pc_out, ras_cnt, ras_ovf, ras_unf);
   endtask

   initial begin
      logic [W-1:0] pc_before;
      logic [W-1:0] exp_unf;
      m_pc = RV; m_ovf = 0; m_unf = 0;
      reset = 1; ld = 0; pcsel = 0; offset = 0; direct = 0; err_clr = 0;
      @(negedge clk);

      // Reset and increment
      cyc(1, 0, 3'd0, 16'h0, 16'h0, 0);
      cyc(1, 0, 3'd0, 16'h0, 16'h0, 0);
      check("reset_pc", pc_out, 16'h0000);
      check("reset_empty", W'(ras_empty), 16'd1);
      cyc(0, 1, 3'd0, 16'h0, 16'h0, 0); check("inc1", pc_out, 16'h0001);
      cyc(0, 1, 3'd0, 16'h0, 16'h0, 0); check("inc2", pc_out, 16'h0002);
      cyc(0, 1, 3'd0, 16'h0, 16'h0, 0); check("inc3", pc_out, 16'h0003);

      // Relative wrap, jump, increment wrap
      cyc(0, 1, 3'd1, 16'hFFFE, 16'h0, 0); check("rel_wrap", pc_out, 16'h0001);
      cyc(0, 1, 3'd2, 16'h0, 16'hFFFF, 0); check("jmp_ffff", pc_out, 16'hFFFF);
      cyc(0, 1, 3'd0, 16'h0, 16'h0, 0);    check("inc_wrap", pc_out, 16'h0000);

      // Single call / return
      cyc(0, 1, 3'd2, 16'h0, 16'h0010, 0);
      cyc(0, 1, 3'd4, 16'h0, 16'h0100, 0);
      check("call_pc", pc_out, 16'h0100);
      check("call_cnt", W'(ras_cnt), 16'd1);
      cyc(0, 1, 3'd5, 16'h0, 16'h0, 0);
      check("ret_pc", pc_out, 16'h0011);
      check("ret_unf", W'(ras_unf), 16'd0);

      // Five calls overflow a depth-4 stack
      cyc(0, 1, 3'd2, 16'h0, 16'h0010, 0);
      for (int i = 1; i <= 5; i++) cyc(0, 1, 3'd4, 16'h0, W'(i * 16'h0100), 0);
      check("ovf_flag", W'(ras_ovf), 16'd1);
      check("ovf_full", W'(ras_full), 16'd1);
      check("ovf_cnt", W'(ras_cnt), 16'd4);
      cyc(0, 1, 3'd5, 16'h0, 16'h0, 0); check("ret1", pc_out, 16'h0401);
      cyc(0, 1, 3'd5, 16'h0, 16'h0, 0); check("ret2", pc_out, 16'h0301);
      cyc(0, 1, 3'd5, 16'h0, 16'h0, 0); check("ret3", pc_out, 16'h0201);
      cyc(0, 1, 3'd5, 16'h0, 16'h0, 0); check("ret4", pc_out, 16'h0101);
`ifdef PC_RAS_TRAP_EN
      exp_unf = 16'hFFF0;
`else
      exp_unf = 16'h0102;
`endif
      cyc(0, 1, 3'd5, 16'h0, 16'h0, 0);
      check("unf_pc", pc_out, exp_unf);
      check("unf_flag", W'(ras_unf), 16'd1);

      // Hold with LD=0 shows next PC but changes nothing
      pc_before = pc_out;
      cyc(0, 0, 3'd4, 16'h0, 16'h0ABC, 0);
      check("hold_pc", pc_out, pc_before);
      check("hold_cnt", W'(ras_cnt), 16'd0);
      reset = 0; ld = 0; pcsel = 3'd4; direct = 16'h0ABC; #1;
      check("hold_next", next_pc, 16'h0ABC);

      // Error clear, then reset in the middle of a call
      cyc(0, 0, 3'd3, 16'h0, 16'h0, 1);
      check("clr_ovf", W'(ras_ovf), 16'd0);
      check("clr_unf", W'(ras_unf), 16'd0);
      cyc(0, 1, 3'd4, 16'h0, 16'h0200, 0);
      cyc(1, 1, 3'd4, 16'h0, 16'h0300, 0);
      check("rst_call_pc", pc_out, RV);
      check("rst_call_cnt", W'(ras_cnt), 16'd0);

      // Random operations against the model
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)),
             W'($urandom), W'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
